gcd_job_sequencer: RTL and testbench

- Upstream feeder for the GCD controller/datapath core.
- Accepts operand pairs on a valid/ready stream and buffers them in a small FIFO.
- Sequences each pair into the core over the shared data bus (A first, then B, with a start pulse), waits for done, and returns the result on a valid/ready output stream.
- Handles zero operands itself, because subtractive GCD never terminates on them. Also guards against a hung core with a timeout.

---
 rtl/gcd_job_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_gcd_job_sequencer.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_job_sequencer.sv
// gcd_job_sequencer: job FIFO plus sequencer feeding a subtractive GCD core.
// Zero operands bypass the core; a hung core is aborted by a wait timer.
module gcd_job_sequencer #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gcd,
  output logic             out_err,
  output logic             gcd_clr,
  output logic             gcd_start,
  output logic [WIDTH-1:0] gcd_data,
  input  logic             gcd_done,
  input  logic [WIDTH-1:0] gcd_result,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_LOAD_A,
    S_LOAD_B,
    S_WAIT,
    S_OUT
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] mem_a [DEPTH];
  logic [WIDTH-1:0] mem_b [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             push, pop, full, empty;
  logic [WIDTH-1:0] head_a, head_b;

  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             err_q, err_d;
  logic [TW-1:0]    timer_q, timer_d;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign head_a   = mem_a[rd_ptr];
  assign head_b   = mem_b[rd_ptr];

  assign out_gcd  = res_q;
  assign out_err  = err_q;
  assign busy     = (state_q != S_IDLE) || !empty;

  // Job storage; contents are defined by the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= in_a;
      mem_b[wr_ptr] <= in_b;
    end
  end

  // FIFO pointers and occupancy; pointers wrap modulo DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)
        count <= count + CW'(1);
      else if (!push && pop)
        count <= count - CW'(1);
    end
  end

  // Sequencer state, operands, wait timer and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      res_q   <= res_d;
      err_q   <= err_d;
      timer_q <= timer_d;
    end
  end

  // Next state: pop in IDLE, drive the core, await done or timeout.
  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    res_d   = res_q;
    err_d   = err_q;
    timer_d = timer_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop    = 1'b1;
          op_a_d = head_a;
          op_b_d = head_b;
          if (head_a == '0 || head_b == '0) begin
            res_d   = head_a | head_b;
            err_d   = 1'b0;
            state_d = S_OUT;
          end else begin
            state_d = S_CLR;
          end
        end
      end
      S_CLR: begin
        state_d = S_LOAD_A;
      end
      S_LOAD_A: begin
        state_d = S_LOAD_B;
      end
      S_LOAD_B: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_q + TW'(1);
        if (gcd_done) begin
          res_d   = gcd_result;
          err_d   = 1'b0;
          state_d = S_OUT;
        end else if (timer_q == T_LAST) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Core-side strobes and out_valid come from registered state only.
  always_comb begin
    gcd_clr   = 1'b0;
    gcd_start = 1'b0;
    gcd_data  = '0;
    out_valid = 1'b0;
    unique case (state_q)
      S_CLR: begin
        gcd_clr = 1'b1;
      end
      S_LOAD_A: begin
        gcd_start = 1'b1;
        gcd_data  = op_a_q;
      end
      S_LOAD_B: begin
        gcd_data = op_b_q;
      end
      S_OUT: begin
        out_valid = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_gcd_job_sequencer.sv
// tb_gcd_job_sequencer: directed plus random jobs against a queue model.
// A behavioural core answers with Euclid's GCD after a chosen delay.
module tb_gcd_job_sequencer;

  localparam int W  = 16;
  localparam int D  = 4;
  localparam int TO = 16;

  typedef struct {
    logic [W-1:0] g;
    logic         e;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_gcd;
  logic         out_err;
  logic         gcd_clr;
  logic         gcd_start;
  logic [W-1:0] gcd_data;
  logic         gcd_done = 1'b0;
  logic [W-1:0] gcd_result = '0;
  logic         busy;

  int n_vec = 0;
  int n_bad = 0;
  int n_out = 0;
  int n_start = 0;
  int n_clr = 0;

  int core_mode = 0;
  int core_lat = 4;

  exp_t sbq[$];

  gcd_job_sequencer #(
    .WIDTH(W),
    .DEPTH(D),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_a(in_a),
    .in_b(in_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_gcd(out_gcd),
    .out_err(out_err),
    .gcd_clr(gcd_clr),
    .gcd_start(gcd_start),
    .gcd_data(gcd_data),
    .gcd_done(gcd_done),
    .gcd_result(gcd_result),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_gcd(logic [W-1:0] a, logic [W-1:0] b);
    logic [W-1:0] t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Cycles after the B load until the core raises done; -1 never.
  function automatic int lat_for(logic [W-1:0] a, logic [W-1:0] b);
    if (core_mode == 0) return core_lat;
    return 1 + int'((a ^ b) % 24);
  endfunction

  // Done lands in wait cycle lat-1; TO wait cycles are allowed.
  function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b);
    exp_t x;
    int lat;
    if (a == 0 || b == 0) begin
      x.g = a | b;
      x.e = 1'b0;
    end else begin
      lat = lat_for(a, b);
      if (lat < 1 || lat > TO) begin
        x.g = '0;
        x.e = 1'b1;
      end else begin
        x.g = ref_gcd(a, b);
        x.e = 1'b0;
      end
    end
    return x;
  endfunction

  // Behavioural core: latch A on start, B next cycle, then count down.
  int cnt = -1;
  logic pend_b = 1'b0;
  logic [W-1:0] ca = '0;
  logic [W-1:0] cb = '0;
  always begin
    @(posedge clk);
    #1;
    if (gcd_clr) begin
      gcd_done = 1'b0;
      cnt = -1;
      pend_b = 1'b0;
    end else if (gcd_start) begin
      ca = gcd_data;
      pend_b = 1'b1;
    end else if (pend_b) begin
      cb = gcd_data;
      pend_b = 1'b0;
      cnt = lat_for(ca, cb);
    end else if (cnt > 0) begin
      cnt--;
    end
    if (cnt == 0) begin
      gcd_done = 1'b1;
      gcd_result = ref_gcd(ca, cb);
      cnt = -1;
    end
  end

  // Scoreboard and hold checks, sampled mid-cycle.
  logic         hold_v = 1'b0;
  logic [W-1:0] hold_g = '0;
  logic         hold_e = 1'b0;
  exp_t         mx;
  always @(negedge clk) begin
    if (rst) begin
      sbq.delete();
      hold_v = 1'b0;
    end else begin
      if (gcd_start) n_start++;
      if (gcd_clr) n_clr++;
      if (hold_v) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_gcd", out_gcd, hold_g);
        chk("hold_err", out_err, hold_e);
      end
      if (in_valid && in_ready) sbq.push_back(model(in_a, in_b));
      if (out_valid && out_ready) begin
        n_out++;
        if (sbq.size() == 0) begin
          chk("spurious_out", 1, 0);
        end else begin
          mx = sbq.pop_front();
          chk("sb_gcd", out_gcd, mx.g);
          chk("sb_err", out_err, mx.e);
        end
      end
      hold_v = out_valid && !out_ready;
      hold_g = out_gcd;
      hold_e = out_err;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_job(input logic [W-1:0] a, input logic [W-1:0] b);
    logic ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    for (int i = 0; i < 200; i++) begin
      ok = in_ready;
      tick();
      if (ok) break;
    end
    if (!ok) chk("push_stall", 0, 1);
    in_valid = 1'b0;
  endtask

  // Pushes one nonzero job into an idle sequencer and checks the
  // load sequence; returns cycles from the head-of-FIFO cycle t.
  task automatic job_timing(input logic [W-1:0] a, input logic [W-1:0] b,
                            input int budget, output int cyc);
    int s0;
    push_job(a, b);
    s0 = n_start;
    chk("t0_clr", gcd_clr, 0);
    tick();
    chk("t1_clr", gcd_clr, 1);
    chk("t1_start", gcd_start, 0);
    tick();
    chk("t2_start", gcd_start, 1);
    chk("t2_data", gcd_data, a);
    chk("t2_clr", gcd_clr, 0);
    tick();
    chk("t3_start", gcd_start, 0);
    chk("t3_data", gcd_data, b);
    tick();
    chk("t4_data", gcd_data, 0);
    cyc = 4;
    while (!out_valid && cyc < budget) begin
      tick();
      cyc++;
    end
    if (!out_valid) chk("out_valid_wait", 0, 1);
    chk("start_count", n_start - s0, 1);
  endtask

  logic [W-1:0] ra, rb;
  bit push_done;
  int cyc, snap, s_clr, s_start;

  function automatic logic [W-1:0] rnd_op();
    if ($urandom_range(0, 9) == 0) return '0;
    return W'($urandom_range(1, 400));
  endfunction

  initial begin
    tick();
    tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_gcd", out_gcd, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_gcd_clr", gcd_clr, 0);
    chk("rst_gcd_start", gcd_start, 0);
    chk("rst_gcd_data", gcd_data, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    out_ready = 1'b1;
    tick();

    // normal job with a five-cycle core
    core_mode = 0;
    core_lat = 5;
    job_timing(48, 18, 40, cyc);
    chk("j1_cycles", cyc, 9);
    chk("j1_gcd", out_gcd, 6);
    chk("j1_err", out_err, 0);
    tick();

    // zero-operand bypass
    s_clr = n_clr;
    s_start = n_start;
    push_job(0, 7);
    chk("z_t0_valid", out_valid, 0);
    push_job(0, 0);
    chk("z1_valid", out_valid, 1);
    chk("z1_gcd", out_gcd, 7);
    chk("z1_err", out_err, 0);
    tick();
    chk("z_gap_valid", out_valid, 0);
    tick();
    chk("z2_valid", out_valid, 1);
    chk("z2_gcd", out_gcd, 0);
    chk("z2_err", out_err, 0);
    tick();
    chk("z_clr_count", n_clr - s_clr, 0);
    chk("z_start_count", n_start - s_start, 0);

    // fill the FIFO behind a stalled result
    out_ready = 1'b0;
    core_lat = 3;
    snap = n_out;
    push_job(60, 42);
    push_job(9, 6);
    push_job(100, 75);
    push_job(13, 0);
    push_job(21, 14);
    chk("full_in_ready", in_ready, 0);
    chk("full_busy", busy, 1);
    in_valid = 1'b1;
    in_a = 17;
    in_b = 5;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_in_ready", in_ready, 0);
    end
    chk("stall_no_out", n_out - snap, 0);
    out_ready = 1'b1;
    push_job(17, 5);
    for (int i = 0; i < 300; i++) begin
      if (sbq.size() == 0 && !busy) break;
      tick();
    end
    chk("fill_results", n_out - snap, 6);
    chk("fill_idle", busy, 0);

    // hung core times out; next job starts with a clear
    core_lat = -1;
    job_timing(12, 8, 40, cyc);
    chk("to_cycles", cyc, 20);
    chk("to_gcd", out_gcd, 0);
    chk("to_err", out_err, 1);
    core_lat = 2;
    job_timing(15, 10, 40, cyc);
    chk("after_to_cycles", cyc, 6);
    chk("after_to_gcd", out_gcd, 5);
    tick();

    // done in the very cycle the timer expires
    core_lat = 16;
    job_timing(27, 18, 40, cyc);
    chk("edge_cycles", cyc, 20);
    chk("edge_gcd", out_gcd, 9);
    chk("edge_err", out_err, 0);
    tick();

    // reset during WAIT with two jobs queued
    core_lat = -1;
    push_job(11, 3);
    push_job(0, 5);
    push_job(4, 6);
    repeat (4) tick();
    chk("mid_busy", busy, 1);
    chk("mid_valid", out_valid, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_in_ready", in_ready, 1);
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_out_gcd", out_gcd, 0);
    chk("mrst_out_err", out_err, 0);
    chk("mrst_gcd_clr", gcd_clr, 0);
    chk("mrst_gcd_start", gcd_start, 0);
    chk("mrst_gcd_data", gcd_data, 0);
    chk("mrst_busy", busy, 0);
    snap = n_out;
    repeat (5) tick();
    chk("mrst_no_out", n_out - snap, 0);
    chk("mrst_still_idle", busy, 0);
    core_lat = 4;
    job_timing(35, 14, 40, cyc);
    chk("post_rst_cycles", cyc, 8);
    chk("post_rst_gcd", out_gcd, 7);
    chk("post_rst_err", out_err, 0);
    tick();

    // random jobs, random gaps and random back-pressure
    core_mode = 1;
    push_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 120; i++) begin
          ra = rnd_op();
          rb = rnd_op();
          push_job(ra, rb);
          repeat ($urandom_range(0, 3)) tick();
        end
        push_done = 1'b1;
      end
      begin
        while (!push_done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          tick();
        end
        out_ready = 1'b1;
      end
    join
    for (int i = 0; i < 2000; i++) begin
      if (sbq.size() == 0 && !busy) break;
      tick();
    end
    chk("drain_queue", sbq.size(), 0);
    chk("drain_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
